// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle control FSM for a small RV32I-subset datapath. Each instruction
// is sequenced IF -> ID -> EX -> (MEM) -> WB. The FSM drives every datapath
// control input, the data-memory strobes, and keeps a retired-instruction
// counter.
//
// Supported classes: R-type ALU, I-type ALU, LW, SW, BEQ. Anything else is
// decoded as ILLEGAL.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an ILLEGAL instruction parks the FSM in HALT and sets the
//               sticky 'illegal' flag; only rst leaves HALT.
//   undefined : an ILLEGAL instruction retires as a NOP. There is no HALT
//               state and no 'illegal' port.
//
// Parameters:
//   CNT_WIDTH  width of the instret counter (wraps modulo 2^CNT_WIDTH)
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous, active-high reset
//   instr     in   [31:0] instruction word, stable during IF and ID
//   Zero      in   ALU zero flag
//   dReady    in   data memory finishes the access this cycle
//   PCSrc     out  select branch target (BEQ taken, in WB)
//   ALUSrc    out  ALU operand 2 = immediate
//   RegWrite  out  register file write enable (WB)
//   MemToReg  out  writeback source = memory read data
//   ALUCtrl   out  [3:0] ALU operation
//   loadPC    out  PC update strobe, one cycle per retired instruction
//   MemRead   out  data memory read strobe (MEM)
//   MemWrite  out  data memory write strobe (MEM)
//   state     out  [2:0] FSM state for debug (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   instret   out  [CNT_WIDTH-1:0] retired-instruction count
//   illegal   out  sticky illegal-instruction flag (ILLEGAL_TRAP_EN only)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 Zero,
  input  logic                 dReady,
  output logic                 PCSrc,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic [3:0]           ALUCtrl,
  output logic                 loadPC,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instret
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                 illegal
`endif
);

  // ALU operation encodings understood by the datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
`ifdef ILLEGAL_TRAP_EN
    ,
    ST_HALT = 3'd5
`endif
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_IALU = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_BEQ  = 3'd4,
    C_ILL  = 3'd5
  } class_t;

  state_t     state_r;
  class_t     cls_r;

  class_t     dec_class;
  logic [3:0] dec_alu;
  logic [6:0] opcode;
  logic [2:0] funct3;

  // Only opcode, funct3 and bit 30 steer control; the rest of the word
  // belongs to the datapath (register indices, immediates).
  logic       unused_instr_bits;
  assign unused_instr_bits = &{instr[31], instr[29:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Shared funct3 -> ALU op map for R-type and I-type. 'alt' selects the
  // SUB/SRA variants; the caller decides when bit 30 is allowed to matter.
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Instruction decode, consumed only at the end of ID. For I-type, bit 30
  // is part of the immediate except for the shift-right pair, so addi with
  // a negative immediate must stay ADD.
  always_comb begin
    dec_class = C_ILL;
    dec_alu   = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct3 != 3'b011) begin
          dec_class = C_R;
          dec_alu   = alu_map(funct3, instr[30]);
        end
      end
      OP_I: begin
        if (funct3 != 3'b011) begin
          dec_class = C_IALU;
          dec_alu   = alu_map(funct3, instr[30] && (funct3 == 3'b101));
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_class = C_LW;
          dec_alu   = ALU_ADD;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec_class = C_SW;
          dec_alu   = ALU_ADD;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          dec_class = C_BEQ;
          dec_alu   = ALU_SUB;
        end
      end
      default: begin
        dec_class = C_ILL;
        dec_alu   = ALU_ADD;
      end
    endcase
  end

  // The branch decision depends on Zero in the same WB cycle, so PCSrc is
  // the one output that is not registered.
  assign PCSrc = (state_r == ST_WB) && (cls_r == C_BEQ) && Zero;
  assign state = state_r;

  // Main sequencer. Outputs are registered and set on the transition into
  // the state that owns them, so they line up with 'state' cycle for cycle.
  // After ID everything comes from cls_r / ALUCtrl, so instr may change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IF;
      cls_r    <= C_ILL;
      ALUCtrl  <= ALU_ADD;
      ALUSrc   <= 1'b0;
      RegWrite <= 1'b0;
      MemToReg <= 1'b0;
      loadPC   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      instret  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IF: begin
          state_r <= ST_ID;
        end

        ST_ID: begin
          cls_r   <= dec_class;
          ALUCtrl <= dec_alu;
          ALUSrc  <= (dec_class == C_IALU) || (dec_class == C_LW) ||
                     (dec_class == C_SW);
          state_r <= ST_EX;
        end

        ST_EX: begin
          if (cls_r == C_LW) begin
            MemRead <= 1'b1;
            state_r <= ST_MEM;
          end else if (cls_r == C_SW) begin
            MemWrite <= 1'b1;
            state_r  <= ST_MEM;
`ifdef ILLEGAL_TRAP_EN
          end else if (cls_r == C_ILL) begin
            illegal <= 1'b1;
            state_r <= ST_HALT;
`endif
          end else begin
            // ILLEGAL lands here only without the trap and retires as a NOP
            loadPC   <= 1'b1;
            RegWrite <= (cls_r == C_R) || (cls_r == C_IALU);
            MemToReg <= 1'b0;
            state_r  <= ST_WB;
          end
        end

        // The strobe stays up through the cycle in which dReady is seen;
        // there is deliberately no timeout.
        ST_MEM: begin
          if (dReady) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            loadPC   <= 1'b1;
            RegWrite <= (cls_r == C_LW);
            MemToReg <= (cls_r == C_LW);
            state_r  <= ST_WB;
          end
        end

        ST_WB: begin
          loadPC   <= 1'b0;
          RegWrite <= 1'b0;
          MemToReg <= 1'b0;
          ALUSrc   <= 1'b0;
          instret  <= instret + CNT_ONE;
          state_r  <= ST_IF;
        end

`ifdef ILLEGAL_TRAP_EN
        ST_HALT: begin
          state_r <= ST_HALT;
        end
`endif

        default: begin
          state_r <= ST_IF;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that sits directly upstream of the datapath and drives all of its control inputs: PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC.
- Sequences each instruction through the states IF, ID, EX, optionally MEM, then WB.
- Issues the data-memory read/write strobes and waits on a dReady handshake before leaving MEM.
- Counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of the instret retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- instr  in  32  current instruction from instruction ROM; must be stable during IF and ID.
- Zero  in  1  ALU zero flag from the datapath.
- dReady  in  1  data memory completes the access this cycle.
- PCSrc  out  1  select branch target for the PC update.
- ALUSrc  out  1  ALU operand 2 = immediate.
- RegWrite  out  1  register file write enable.
- MemToReg  out  1  writeback source = memory read data.
- ALUCtrl  out  4  ALU operation.
- loadPC  out  1  PC update strobe.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- state  out  3  current FSM state, for debug.
- instret  out  CNT_WIDTH  retired-instruction count.
- illegal  out  1  sticky illegal-instruction flag; present only with the feature macro defined.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Reset:
  - state=IF, instret=0, illegal=0.
  - All strobes low: PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite.
  - ALUCtrl=0010 (ADD).
  - Reset wins over every other event. Asserting rst in MEM drops MemRead/MemWrite the next cycle.
- IF -> ID unconditionally; no strobes asserted.
- ID:
  - Decode instr; latch class (R, I-ALU, LW, SW, BEQ, ILLEGAL) and ALUCtrl into registers.
  - Always go to EX.
- Outputs from EX through WB come from the latched registers only; instr may change after ID.
- ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- R-type (opcode 0110011), mapped by funct3:
  - 000: ADD, or SUB when instr[30]=1.
  - 001: SLL. 010: SLT. 100: XOR.
  - 101: SRL, or SRA when instr[30]=1.
  - 110: OR. 111: AND.
  - 011: ILLEGAL.
- I-ALU (opcode 0010011):
  - Same funct3 map as R-type.
  - instr[30] is honoured only for funct3=101; addi ignores instr[30].
  - funct3=011 is ILLEGAL.
- Memory and branch decode:
  - LW: opcode 0000011 with funct3 010, ALUCtrl ADD.
  - SW: opcode 0100011 with funct3 010, ALUCtrl ADD.
  - BEQ: opcode 1100011 with funct3 000, ALUCtrl SUB.
  - Every other opcode/funct3 combination is ILLEGAL.
- EX:
  - ALUSrc=1 for I-ALU, LW and SW; 0 otherwise.
  - LW/SW go to MEM; all other classes go to WB.
- MEM:
  - MemRead=1 (LW) or MemWrite=1 (SW), held every cycle while dReady=0.
  - The strobe stays high in the cycle dReady=1; the FSM then goes to WB.
  - No timeout.
- WB:
  - loadPC=1 for exactly one cycle.
  - RegWrite=1 for R, I-ALU and LW. MemToReg=1 for LW only.
  - PCSrc = (class==BEQ) & Zero, sampled combinationally in WB.
  - instret increments and wraps modulo 2^CNT_WIDTH.
  - Next state IF.
- ALUSrc and ALUCtrl hold their latched values from EX through WB.
- Latency:
  - R, I-ALU, BEQ: 4 cycles.
  - LW, SW: 5 cycles plus one cycle per dReady=0 cycle in MEM.
- dReady outside MEM is ignored.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - An ILLEGAL class goes EX -> HALT; illegal sets to 1 and sticks.
  - HALT asserts no strobes, never pulses loadPC, does not increment instret, and is left only by rst.
- Undefined:
  - The illegal port and HALT state are absent.
  - An ILLEGAL instruction executes as a NOP: EX -> WB with RegWrite=0, PCSrc=0, loadPC=1, and instret increments.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3):
  - States 0,1,2,4.
  - ALUCtrl=0010, ALUSrc=0.
  - RegWrite=1 and loadPC=1 only in cycle 4; instret=1.
- ALU decode:
  - sub 0x402081B3 -> ALUCtrl 0110.
  - srai 0x4020D193 -> ALUSrc=1, ALUCtrl 1010.
  - addi x1,x0,-1 (0xFFF00093) -> ALUCtrl 0010, not SUB.
- lw x5,8(x1) (0x0080A283), dReady low for 3 MEM cycles:
  - MemRead high 4 cycles.
  - WB: MemToReg=1, RegWrite=1.
  - Total 8 cycles.
- beq x1,x2,8 (0x00208463):
  - Zero=1 -> WB PCSrc=1, loadPC=1, RegWrite=0.
  - Repeat with Zero=0 -> PCSrc=0.
- sw x5,8(x1) (0x0050A423), dReady=1:
  - MemWrite high exactly 1 cycle, MemRead 0.
  - WB: RegWrite=0, loadPC=1.
- Reset and illegal handling:
  - rst during MEM of lw -> next cycle state=0, MemRead=0, instret=0.
  - Then 0x0000007F, macro defined -> state=5, illegal=1, no loadPC.
  - Macro undefined -> NOP, loadPC=1, instret+1.
